// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte producers.
// Sequences chip-select, load and start strobes, then waits for done under a watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 20000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*DW-1:0]      req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    cs_o,
    output logic [DW-1:0]           data_o,
    output logic                    byte_ready_o,
    output logic                    t_byte_o,
    input  logic                    done_i,
    output logic                    busy_o,
    output logic [$clog2(NREQ)-1:0] grant_id_o,
    output logic                    timeout_o
);

    localparam int unsigned GW  = $clog2(NREQ);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic [WDW-1:0]  wd_q, wd_d;

    logic            pick_vld_c;
    logic [GW-1:0]   pick_idx_c;
    logic            wd_hit_c;

    // Requester index base+off, wrapping at NREQ (both operands are below NREQ).
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return GW'(sum);
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_vld_c && req_valid_i[rr_idx(rr_q, i)]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = rr_idx(rr_q, i);
            end
        end
    end

    assign wd_hit_c = (wd_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_vld_c) state_d = S_LOAD;
            S_LOAD:  state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (done_i || wd_hit_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Done has priority over the watchdog, so timeout only fires without done.
    always_comb begin
        req_ready_o  = '0;
        cs_o         = 1'b0;
        byte_ready_o = 1'b0;
        t_byte_o     = 1'b0;
        timeout_o    = 1'b0;
        case (state_q)
            S_IDLE:  if (pick_vld_c) req_ready_o = NREQ'(1) << pick_idx_c;
            S_LOAD: begin
                cs_o         = 1'b1;
                byte_ready_o = 1'b1;
            end
            S_START: begin
                cs_o     = 1'b1;
                t_byte_o = 1'b1;
            end
            S_WAIT: begin
                cs_o      = 1'b1;
                timeout_o = wd_hit_c && !done_i;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

    always_comb begin
        rr_d    = rr_q;
        grant_d = grant_q;
        data_d  = data_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld_c) begin
                    data_d  = req_data_i[32'(pick_idx_c) * DW +: DW];
                    grant_d = pick_idx_c;
                end
            end
            S_START: wd_d = '0;
            S_WAIT: begin
                wd_d = wd_q + WDW'(1);
                if (done_i || wd_hit_c) begin
                    rr_d = rr_idx(grant_q, 1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_q    <= '0;
            grant_q <= '0;
            data_q  <= '0;
            wd_q    <= '0;
        end else begin
            rr_q    <= rr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
        end
    end

    assign data_o     = data_q;
    assign grant_id_o = grant_q;

endmodule
